bcd_formatter: RTL and testbench
================================

BCD_FORMATTER -- requirements
Module: bcd_formatter

Interface
REQ-001 SHALL have parameter BIN_W, default 16: width of the binary input, legal range 14..16.
REQ-002 SHALL have parameter MAX_VAL, default 9999: largest value representable on 4 digits.
REQ-003 SHALL have clk_i, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have por_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have bin_i, input, BIN_W: unsigned binary value to convert.
REQ-006 SHALL have valid_i, input, 1: bin_i is valid this cycle.
REQ-007 SHALL have ready_o, output, 1: block can accept a new value.
REQ-008 SHALL have data_disp_o, output, [3:0][3:0]: four BCD nibbles; element 0 = thousands, element 3 = units.
REQ-009 SHALL have valid_o, output, 1: one-cycle pulse when data_disp_o has just been updated.
REQ-010 SHALL have ovf_o, output, 1: last accepted value exceeded MAX_VAL.

Function
REQ-011 SHALL implement the FSM states IDLE, CONV and DONE, held in a registered state variable.
REQ-012 SHALL drive ready_o = (state == IDLE) combinationally, with no other term.
REQ-013 SHALL accept an input only on a cycle where valid_i && ready_o; on acceptance it captures min(bin_i, MAX_VAL) into the shift register, captures (bin_i > MAX_VAL) into an overflow flag, clears the BCD accumulator and its bit counter, and moves to CONV.
REQ-014 SHALL ignore valid_i while not in IDLE: no queueing and no change to the in-flight conversion.
REQ-015 SHALL, in CONV, perform one double-dabble step per cycle: add 3 to each BCD nibble >= 5, then shift {bcd, bin} left by one bit.
REQ-016 SHALL leave CONV for DONE after exactly BIN_W CONV cycles, tracked by a counter of width clog2(BIN_W+1).
REQ-017 SHALL, on the DONE cycle, load data_disp_o and ovf_o from the accumulator and flag, assert valid_o for exactly that cycle, and return to IDLE.
REQ-018 SHALL make data_disp_o and valid_o change exactly BIN_W+1 cycles after the accepting edge (17 cycles with the default).
REQ-019 SHALL hold data_disp_o and ovf_o stable between DONE cycles, so the downstream display stage can sample them at any time.
REQ-020 SHALL produce nibbles only in 0..9; values above MAX_VAL display as 9,9,9,9 with ovf_o = 1.
REQ-021 SHALL accept a valid_i presented in the cycle after DONE, giving back-to-back conversions every BIN_W+2 cycles.
REQ-022 SHALL treat any illegal state encoding as IDLE on the next edge.

Reset
REQ-023 SHALL, while por_i = 1, immediately force: state = IDLE, data_disp_o = {0,0,0,0}, valid_o = 0, ovf_o = 0, and the internal counter, accumulator and shift register = 0.
REQ-024 SHALL, when por_i is asserted mid-conversion, abort the conversion with no valid_o pulse; after release, ready_o = 1 on the first cycle.

Structure
REQ-025 SHALL place the state typedef (IDLE/CONV/DONE), NDIG = 4 and the default MAX_VAL in shared package disp_pkg, which the display stage also imports.
REQ-026 SHALL contain one sub-module, bcd_adj3: combinational 4-bit "if >= 5 then +3", instantiated NDIG times.
REQ-027 SHALL connect data_disp_o directly to the display block's data_disp input, with no glue logic.

Verification
REQ-028 Bench SHALL cover: reset, then bin_i = 1234 with one valid_i pulse -> after 17 cycles data_disp_o = {1,2,3,4}, valid_o high for 1 cycle, ovf_o = 0.
REQ-029 Bench SHALL cover: bin_i = 0, then 9999 -> {0,0,0,0}, then {9,9,9,9} with ovf_o = 0.
REQ-030 Bench SHALL cover: bin_i = 10000, then 65535 -> both give {9,9,9,9} with ovf_o = 1; then 42 -> {0,0,4,2} with ovf_o = 0.
REQ-031 Bench SHALL cover: valid_i held high with bin_i changing every cycle -> only values sampled while ready_o = 1 are converted, one valid_o pulse every 18 cycles.
REQ-032 Bench SHALL cover: por_i asserted 5 cycles into converting 4321 -> outputs 0 immediately, no valid_o pulse; ready_o = 1 after release; a new 4321 request then completes correctly.
REQ-033 Bench SHALL cover: random bin_i over 0..65535 against a reference model, checking nibbles, ovf_o and the exact latency.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared display definitions: FSM states, digit count, default limit.
// Imported by the formatter and by the downstream display stage.
package disp_pkg;

  localparam int NDIG        = 4;
  localparam int DEF_MAX_VAL = 9999;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } fsm_e;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction.
// Adds 3 to a BCD nibble of 5 or more before the shift.
module bcd_adj3 (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_formatter.sv
// Binary to 4-digit BCD converter, one double-dabble step per cycle.
// Clamps to MAX_VAL and flags overflow; outputs held between updates.
module bcd_formatter
  import disp_pkg::*;
#(
  parameter int BIN_W   = 16,
  parameter int MAX_VAL = DEF_MAX_VAL
) (
  input  logic                  clk_i,
  input  logic                  por_i,
  input  logic [BIN_W-1:0]      bin_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [3:0][3:0]       data_disp_o,
  output logic                  valid_o,
  output logic                  ovf_o
);

  localparam int CW = $clog2(BIN_W + 1);
  localparam int BW = NDIG * 4;
  localparam logic [BIN_W-1:0] MAXV = BIN_W'(MAX_VAL);

  fsm_e                  state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]      bin_q, bin_d;
  logic [NDIG-1:0][3:0]  bcd_q, bcd_d;
  logic                  flag_q, flag_d;
  logic [NDIG-1:0][3:0]  disp_q, disp_d;
  logic                  ovf_q, ovf_d;
  logic                  vld_q, vld_d;

  logic [NDIG-1:0][3:0]  adj;
  logic [BW+BIN_W-1:0]   shv;

  for (genvar g = 0; g < NDIG; g++) begin : g_adj
    bcd_adj3 u_adj (
      .d_i (bcd_q[g]),
      .d_o (adj[g])
    );
  end

  assign shv = {adj, bin_q} << 1;

  assign ready_o     = (state_q == IDLE);
  assign data_disp_o = disp_q;
  assign valid_o     = vld_q;
  assign ovf_o       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    flag_d  = flag_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    vld_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          bin_d   = (bin_i > MAXV) ? MAXV : bin_i;
          flag_d  = (bin_i > MAXV);
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, bin_d} = shv;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BIN_W - 1)) state_d = DONE;
      end
      DONE: begin
        // Accumulator holds thousands in the top nibble; display wants it first.
        for (int i = 0; i < NDIG; i++) disp_d[i] = bcd_q[NDIG-1-i];
        ovf_d   = flag_q;
        vld_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge por_i) begin
    if (por_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      flag_q  <= 1'b0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      flag_q  <= flag_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      vld_q   <= vld_d;
    end
  end

endmodule

// File: tb/tb_bcd_formatter.sv
// Scoreboard bench for bcd_formatter: acceptances push expected results,
// a negedge monitor pops on valid_o and checks value, overflow and latency.
module tb_bcd_formatter;

  logic             clk = 1'b0;
  logic             por = 1'b1;
  logic [15:0]      bin = '0;
  logic             vin = 1'b0;
  logic             rdy;
  logic [3:0][3:0]  disp;
  logic             vout;
  logic             ovf;

  bcd_formatter #(.BIN_W(16), .MAX_VAL(9999)) dut (
    .clk_i       (clk),
    .por_i       (por),
    .bin_i       (bin),
    .valid_i     (vin),
    .ready_o     (rdy),
    .data_disp_o (disp),
    .valid_o     (vout),
    .ovf_o       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] disp;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t  q[$];
  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  int    last_acc = -100;
  int    pulses = 0;
  logic [15:0] last_disp = '0;
  logic        last_ovf = 1'b0;

  function automatic exp_t model(input int v, input int acc);
    exp_t e;
    int c;
    c = (v > 9999) ? 9999 : v;
    e.disp[3:0]   = 4'(c / 1000);
    e.disp[7:4]   = 4'((c / 100) % 10);
    e.disp[11:8]  = 4'((c / 10) % 10);
    e.disp[15:12] = 4'(c % 10);
    e.ovf = (v > 9999);
    e.acc = acc;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic exp_rdy;
    if (por) begin
      q.delete();
      last_acc = -100;
      last_disp = '0;
      last_ovf = 1'b0;
      checks++;
      if (disp !== 16'h0 || vout !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL reset_out: disp=%h valid=%b ovf=%b need 0000/0/0",
                 disp, vout, ovf);
      end
    end else begin
      if (vout === 1'b1) begin
        pulses++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid at cyc %0d disp=%h", cyc, disp);
        end else begin
          e = q.pop_front();
          if (disp !== e.disp || ovf !== e.ovf || cyc != e.acc + 18) begin
            errors++;
            $display("FAIL result: disp=%h ovf=%b cyc=%0d need %h %b %0d",
                     disp, ovf, cyc, e.disp, e.ovf, e.acc + 18);
          end
        end
        last_disp = disp;
        last_ovf = ovf;
      end else begin
        checks++;
        if (disp !== last_disp || ovf !== last_ovf) begin
          errors++;
          $display("FAIL hold: disp=%h ovf=%b need %h %b",
                   disp, ovf, last_disp, last_ovf);
        end
      end
      exp_rdy = !(cyc >= last_acc + 1 && cyc <= last_acc + 17);
      checks++;
      if (rdy !== exp_rdy) begin
        errors++;
        $display("FAIL ready at cyc %0d: got %b need %b", cyc, rdy, exp_rdy);
      end
      if (vin && rdy) begin
        q.push_back(model(int'(bin), cyc));
        last_acc = cyc;
      end
    end
  end

  task automatic send(input int v);
    int n = 0;
    while (!rdy && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    bin = 16'(v);
    vin = 1'b1;
    @(posedge clk); #1;
    vin = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results still pending", q.size());
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1 por = 1'b0;
    @(posedge clk); #1;

    send(1234);  drain();
    send(0);     send(9999);  drain();
    send(10000); send(65535); send(42); drain();

    p0 = pulses;
    for (int i = 0; i < 60; i++) begin
      bin = 16'($urandom);
      vin = 1'b1;
      @(posedge clk); #1;
    end
    vin = 1'b0;
    drain();
    checks++;
    if (pulses - p0 != 4) begin
      errors++;
      $display("FAIL stream_pulses: got %0d need 4", pulses - p0);
    end

    send(4321);
    repeat (4) @(posedge clk);
    #1 por = 1'b1;
    repeat (2) @(posedge clk);
    #1 por = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_por: got %b need 1", rdy);
    end
    @(posedge clk); #1;
    send(4321); drain();

    for (int i = 0; i < 150; i++) begin
      send(int'($urandom_range(0, 65535)));
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
